// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: unpacks a length-framed byte stream into big-endian
// 32-bit words, writes them from address 0 and releases the CPU only after a matching XOR checksum.
module imem_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         asm_q, asm_d;
  logic [7:0]          xor_q, xor_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic                rdy_q, rdy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cpu_rst_q, cpu_rst_d;

  logic                xfer;
  logic [15:0]         len_full;
  logic [ADDR_W:0]     wl_inc;

  assign xfer     = rx_valid & rdy_q;
  assign len_full = {len_hi_q, rx_data};
  assign wl_inc   = wl_q + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    xor_d      = xor_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    wl_d       = wl_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLenHi;
          wl_d       = '0;
          xor_d      = '0;
          byte_idx_d = '0;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_hi_d = rx_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          if (32'(len_full) > DEPTH) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            len_d   = len_full[ADDR_W:0];
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          xor_d      = xor_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          asm_d      = {asm_q[15:0], rx_data};
          // Fourth byte completes a word; the write pulse appears next cycle.
          if (byte_idx_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = wl_q[ADDR_W-1:0];
            data_d = {asm_q, rx_data};
            wl_d   = wl_inc;
            if (wl_inc == len_q) begin
              state_d = StCheck;
            end
          end
        end
      end
      StCheck: begin
        if (xfer) begin
          state_d = (rx_data == xor_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    rdy_d     = (state_d == StLenHi) || (state_d == StLenLo) ||
                (state_d == StData)  || (state_d == StCheck);
    done_d    = (state_d == StDone);
    err_d     = (state_d == StErr);
    cpu_rst_d = (state_d != StDone);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_hi_q   <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      xor_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      wl_q       <= '0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      xor_q      <= xor_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wl_q       <= wl_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign rx_ready     = rdy_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_data    = data_q;
  assign cpu_reset    = cpu_rst_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a frame-level model queues the expected memory writes and
// final status; a negedge monitor pops and compares every imem_we pulse.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .cpu_reset   (cpu_reset),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] payload[$];
  logic [ADDR_W+31:0] exp_q[$];  // {addr, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    logic [ADDR_W+31:0] e;
    if (reset === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write (t=%0t)",
                 imem_addr, imem_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e[ADDR_W+31:32]));
        check("write_data", imem_data, e[31:0]);
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_data"}, imem_data, 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int n;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    rx_valid = 1'b0;
    repeat (gap) begin
      rx_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rx_ready_timeout: got rx_ready 0 for 50 cycles, required 1 (t=%0t)", $time);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Frame-level reference: words go to addresses 0..N-1 when N fits, done iff checksum matches.
  task automatic run_frame(input logic [15:0] n, input logic [7:0] flip, input int max_gap);
    logic [7:0] xr;
    bit         fits;
    bit         exp_done;
    xr   = 8'h00;
    fits = (32'(n) <= DEPTH);
    foreach (payload[k]) begin
      xr = xr ^ payload[k][31:24] ^ payload[k][23:16] ^ payload[k][15:8] ^ payload[k][7:0];
    end
    if (fits) begin
      foreach (payload[k]) exp_q.push_back({ADDR_W'(k), payload[k]});
    end

    pulse_start();
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), 32'd0);
    check("start_cpu_reset", 32'(cpu_reset), 32'd1);
    check("start_words_loaded", 32'(words_loaded), 32'd0);
    check("start_rx_ready", 32'(rx_ready), 32'd1);

    send_byte(n[15:8], max_gap);
    send_byte(n[7:0], max_gap);

    if (!fits) begin
      check("len_err_error", 32'(error), 32'd1);
      check("len_err_done", 32'(done), 32'd0);
      check("len_err_rx_ready", 32'(rx_ready), 32'd0);
      check("len_err_cpu_reset", 32'(cpu_reset), 32'd1);
      check("len_err_words_loaded", 32'(words_loaded), 32'd0);
      rx_valid = 1'b1;
      repeat (6) begin
        rx_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
      rx_valid = 1'b0;
      check("len_err_pending_writes", 32'(exp_q.size()), 32'd0);
      return;
    end

    foreach (payload[k]) begin
      send_byte(payload[k][31:24], max_gap);
      send_byte(payload[k][23:16], max_gap);
      send_byte(payload[k][15:8], max_gap);
      send_byte(payload[k][7:0], max_gap);
    end
    send_byte(xr ^ flip, max_gap);

    exp_done = (flip == 8'h00);
    check("end_done", 32'(done), 32'(exp_done));
    check("end_error", 32'(error), 32'(!exp_done));
    check("end_cpu_reset", 32'(cpu_reset), 32'(!exp_done));
    check("end_words_loaded", 32'(words_loaded), 32'(n));
    check("end_rx_ready", 32'(rx_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("end_pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] rn;
    logic [7:0]  rflip;
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Case 1 and 2: good and bad checksum.
    payload = '{32'hDEADBEEF, 32'h01234567};
    run_frame(16'd2, 8'h00, 0);
    run_frame(16'd2, 8'h01, 0);

    // Case 3: N = 1025 rejected.
    payload.delete();
    run_frame(16'd1025, 8'h00, 0);

    // Case 4: empty frame, then reload from DONE.
    run_frame(16'd0, 8'h00, 0);
    payload = '{32'hDEADBEEF, 32'h01234567};
    run_frame(16'd2, 8'h00, 0);

    // Case 5: gaps, then reset mid-load after two payload bytes.
    run_frame(16'd2, 8'h00, 5);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outs("midload_reset");
    #3;
    reset = 1'b1;
    rx_valid = 1'b1;
    repeat (8) begin
      rx_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    check("post_reset_rx_ready", 32'(rx_ready), 32'd0);
    check("post_reset_words_loaded", 32'(words_loaded), 32'd0);
    check("post_reset_cpu_reset", 32'(cpu_reset), 32'd1);

    // Case 6: full-depth load, word k = k.
    payload.delete();
    for (int k = 0; k < int'(DEPTH); k++) payload.push_back(32'(k));
    run_frame(16'(DEPTH), 8'h00, 0);
    check("full_last_addr", 32'(imem_addr), 32'h3FF);
    check("full_last_data", imem_data, 32'h000003FF);

    // Random frames.
    for (int t = 0; t < 8; t++) begin
      rn = 16'($urandom_range(12, 1));
      payload.delete();
      for (int k = 0; k < int'(rn); k++) payload.push_back($urandom);
      rflip = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 1)) : 8'h00;
      run_frame(rn, rflip, 3);
    end
    payload.delete();
    run_frame(16'($urandom_range(65535, 1025)), 8'h00, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU instruction memory; the write side of the instruction store the CPU fetches from.
- Receives a framed byte stream over a valid/ready handshake and packs the bytes into 32-bit words, big-endian.
- Writes the words to consecutive instruction-memory addresses from 0, then checks an XOR checksum.
- Holds the CPU in reset until a load completes cleanly.

Parameters:
- ADDR_W, 10, instruction-memory word-address width
- DEPTH, 1024, number of instruction-memory words; maximum accepted length

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- rx_valid  in  1  byte-stream valid
- rx_data  in  8  byte-stream data
- rx_ready  out  1  loader accepts a byte this cycle; transfer = rx_valid & rx_ready
- imem_we  out  1  instruction-memory write enable, one-cycle pulse
- imem_addr  out  ADDR_W  word address being written
- imem_data  out  32  word being written
- cpu_reset  out  1  active-high hold for the CPU; 1 = CPU held in reset
- done  out  1  load completed and checksum matched
- error  out  1  load failed: length too large, or checksum mismatch
- words_loaded  out  ADDR_W+1  number of words written in the current or last load

Behaviour:
- Frame format, in order:
  - LEN_HI byte, then LEN_LO byte: N = {LEN_HI, LEN_LO}, 16 bits.
  - 4*N payload bytes; the first byte of each word goes to bits 31:24.
  - One checksum byte = XOR of all payload bytes. The length bytes are not included.
- Reset (reset=0, asynchronous): state IDLE.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_data=0, cpu_reset=1, done=0, error=0, words_loaded=0.
  - Internal byte index, word counter and running XOR are cleared.
- States:
  - IDLE: rx_ready=0. start -> LEN_HI.
  - LEN_HI: rx_ready=1. On transfer, latch the high byte -> LEN_LO.
  - LEN_LO: rx_ready=1. On transfer:
    - N > DEPTH -> ERR; no writes occur.
    - N == 0 -> CHECK.
    - Otherwise -> DATA.
  - DATA: rx_ready=1 continuously, including the cycle of a memory write.
    - Each transfer shifts the byte into the assembly register and XORs it into the running checksum.
    - On the 4th byte of a word:
      - Load imem_data with the completed word and imem_addr with the word index.
      - Pulse imem_we high for exactly the next cycle.
      - Increment words_loaded in that same cycle.
    - The next byte may be accepted during the write cycle.
    - After word N-1's 4th byte -> CHECK.
  - CHECK: rx_ready=1. On transfer, compare the byte to the running XOR:
    - Equal -> DONE.
    - Not equal -> ERR.
  - DONE: rx_ready=0, done=1, cpu_reset=0.
  - ERR: rx_ready=0, error=1, cpu_reset=1.
- start handling:
  - start in DONE or ERR -> LEN_HI. In the following cycle: done=0, error=0, cpu_reset=1, words_loaded=0, XOR cleared.
  - start in LEN_HI, LEN_LO, DATA or CHECK is ignored.
- Timing:
  - imem_we is registered and asserted only in DATA or in the cycle after the final word transfer. It is never asserted in any other state.
  - The last word write may complete in the same cycle as entry to CHECK.
  - Gaps: rx_valid may drop at any time; state holds with no timeout.
  - rx_data is ignored when rx_ready=0.
- Reset mid-load returns immediately to reset values. A partial word is discarded and not written.
- A failed checksum does not undo writes already made; cpu_reset remains 1.

Test Plan:
1. Reset, start, stream 00 02 DE AD BE EF 01 23 45 67 22 -> required:
   - imem_we pulses: addr 0 = DEADBEEF, addr 1 = 01234567.
   - Afterwards done=1, error=0, cpu_reset=0, words_loaded=2.
2. Same stream but checksum 23 -> required:
   - Both writes still occur.
   - error=1, done=0, cpu_reset=1.
3. Length bytes 04 01 (N=1025) -> required:
   - ERR right after the LEN_LO transfer; no imem_we pulses.
   - rx_ready=0 afterwards.
4. Length 00 00 then checksum 00 -> required: done=1, words_loaded=0, no writes. Then start plus the stream from case 1 -> required: done drops the cycle after start, and the reload succeeds.
5. Case-1 stream with random 0-5 cycle rx_valid gaps -> required: identical writes and result. Separately, assert reset after 2 payload bytes -> required: all outputs at reset values, no write, later bytes ignored (rx_ready=0).
6. N=1024, word k = k -> required:
   - Last write has addr 3FF, data 000003FF.
   - words_loaded=1024; done=1 with the correct checksum.
